alu_issue_sequencer: RTL

Command-driven sequencer wrapped around the combinational `alu`. It accepts one command (opcode, element count, reduce flag) and streams operand pairs from an upstream valid/ready source into the ALU through a registered issue stage. It captures ALU results into a small result FIFO, either per element or as one wrapped 8-bit reduction. It is the block directly upstream of `alu` (drives its inputs) and collects its output for the tensor-core datapath.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu.sv | 27 ++
 rtl/result_fifo.sv | 58 +++++
 rtl/alu_issue_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, sequencer state encoding and the
// result FIFO payload.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OPC_W  = 8;

    localparam logic [OPC_W-1:0] ADD          = 8'd0;
    localparam logic [OPC_W-1:0] SUBTRACT     = 8'd1;
    localparam logic [OPC_W-1:0] MULTIPLY     = 8'd2;
    localparam logic [OPC_W-1:0] EQUALS       = 8'd3;
    localparam logic [OPC_W-1:0] GREATER_THAN = 8'd4;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_FLUSH = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } res_entry_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; arithmetic wraps modulo 256, compares are signed
// and return 0/1. Output is 0 when not enabled.
module alu
    import alu_pkg::*;
(
    input  logic              enable_i,
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [DATA_W-1:0] input1_i,
    input  logic [DATA_W-1:0] input2_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        if (enable_i) begin
            case (opcode_i)
                ADD:          result_o = input1_i + input2_i;
                SUBTRACT:     result_o = input1_i - input2_i;
                MULTIPLY:     result_o = input1_i * input2_i;
                EQUALS:       result_o = DATA_W'(input1_i == input2_i);
                GREATER_THAN: result_o = DATA_W'($signed(input1_i) > $signed(input2_i));
                default:      result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/result_fifo.sv
// Synchronous result FIFO holding {last, data} entries; depth must be a power
// of two so the pointers wrap naturally.
module result_fifo
    import alu_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  res_entry_t       push_data_i,
    input  logic             pop_i,
    output res_entry_t       head_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    res_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so push while full is
    // allowed when paired with a pop.
    assign pop_ok  = pop_i & valid_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Command-driven sequencer: streams operand pairs through a registered issue
// stage into the ALU and collects per-element or reduced results in a FIFO.
module alu_issue_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 8
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              cmd_valid_in,
    output logic              cmd_ready_out,
    input  logic [OPC_W-1:0]  cmd_opcode_in,
    input  logic [LEN_W-1:0]  cmd_len_in,
    input  logic              cmd_reduce_in,
    input  logic              op_valid_in,
    output logic              op_ready_out,
    input  logic [DATA_W-1:0] op_a_in,
    input  logic [DATA_W-1:0] op_b_in,
    output logic              alu_enable_out,
    output logic [OPC_W-1:0]  alu_opcode_out,
    output logic [DATA_W-1:0] alu_input1_out,
    output logic [DATA_W-1:0] alu_input2_out,
    input  logic [DATA_W-1:0] alu_result_in,
    output logic              res_valid_out,
    input  logic              res_ready_in,
    output logic [DATA_W-1:0] res_data_out,
    output logic              res_last_out,
    output logic              busy_out
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    seq_state_t        state_q, state_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic              reduce_q, reduce_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              issue_valid_q, issue_valid_d;
    logic              issue_last_q, issue_last_d;
    logic [DATA_W-1:0] in1_q, in1_d;
    logic [DATA_W-1:0] in2_q, in2_d;

    logic              cmd_ready;
    logic              op_ready;
    logic              push;
    res_entry_t        push_entry;
    logic              pop;
    res_entry_t        fifo_head;
    logic              fifo_valid;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q       <= SEQ_IDLE;
            opcode_q      <= '0;
            reduce_q      <= 1'b0;
            remaining_q   <= '0;
            acc_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_last_q  <= 1'b0;
            in1_q         <= '0;
            in2_q         <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            reduce_q      <= reduce_d;
            remaining_q   <= remaining_d;
            acc_q         <= acc_d;
            issue_valid_q <= issue_valid_d;
            issue_last_q  <= issue_last_d;
            in1_q         <= in1_d;
            in2_q         <= in2_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        reduce_d      = reduce_q;
        remaining_d   = remaining_q;
        acc_d         = acc_q;
        issue_valid_d = 1'b0;
        issue_last_d  = issue_last_q;
        in1_d         = in1_q;
        in2_d         = in2_q;
        cmd_ready     = 1'b0;
        op_ready      = 1'b0;
        push          = 1'b0;
        push_entry    = '0;

        // Capture the ALU result for the live issue entry.
        if (issue_valid_q) begin
            if (reduce_q) begin
                acc_d = acc_q + alu_result_in;
            end else begin
                push            = 1'b1;
                push_entry.last = issue_last_q;
                push_entry.data = alu_result_in;
            end
        end

        case (state_q)
            SEQ_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid_in) begin
                    opcode_d = cmd_opcode_in;
                    reduce_d = cmd_reduce_in;
                    if (cmd_len_in != '0) begin
                        acc_d       = '0;
                        remaining_d = cmd_len_in;
                        state_d     = SEQ_RUN;
                    end
                end
            end
            SEQ_RUN: begin
                // Reserve a FIFO slot for every element in flight.
                op_ready = reduce_q |
                           ((fifo_count + CNT_W'(issue_valid_q)) < CNT_W'(FIFO_DEPTH));
                if (op_valid_in && op_ready) begin
                    issue_valid_d = 1'b1;
                    in1_d         = op_a_in;
                    in2_d         = op_b_in;
                    issue_last_d  = (remaining_q == LEN_W'(1));
                    remaining_d   = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = SEQ_FLUSH;
                    end
                end
            end
            SEQ_FLUSH: begin
                if (!reduce_q) begin
                    if (issue_valid_q) begin
                        state_d = SEQ_IDLE;
                    end
                end else if (!issue_valid_q && !fifo_full) begin
                    push            = 1'b1;
                    push_entry.last = 1'b1;
                    push_entry.data = acc_q;
                    state_d         = SEQ_IDLE;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    assign pop = res_ready_in & fifo_valid;

    result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_result_fifo (
        .clk_i      (clock_in),
        .rst_ni     (reset_in),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .valid_o    (fifo_valid),
        .full_o     (fifo_full),
        .count_o    (fifo_count)
    );

    assign cmd_ready_out  = cmd_ready;
    assign op_ready_out   = op_ready;
    assign alu_enable_out = issue_valid_q;
    assign alu_opcode_out = opcode_q;
    assign alu_input1_out = in1_q;
    assign alu_input2_out = in2_q;
    assign res_valid_out  = fifo_valid;
    assign res_data_out   = fifo_head.data;
    assign res_last_out   = fifo_valid & fifo_head.last;
    assign busy_out       = (state_q != SEQ_IDLE) | issue_valid_q;

endmodule
